// File: rtl/inert_pkg.sv
// Shared types and constants for the inertial-sensor SPI reader.
//   state_t      : sequencer states, power-up through read burst and holdoff
//   INIT_CMD1..3 : sensor init register writes, issued in order after power-up
//   RD_BASE_ADDR : address of the first rate byte; the burst reads six consecutive bytes
//   HOLDOFF_CLKS : dwell after a burst so a releasing INT is not seen again
package inert_pkg;

    typedef enum logic [3:0] {
        StPwrWait,
        StInit1,
        StInit2,
        StInit3,
        StWaitInt,
        StRd0,
        StRd1,
        StRd2,
        StRd3,
        StRd4,
        StRd5,
        StHoldoff
    } state_t;

    localparam logic [15:0] INIT_CMD1 = 16'h0D02;  // INT on gyro data-ready
    localparam logic [15:0] INIT_CMD2 = 16'h1160;  // gyro 416 Hz, 250 dps
    localparam logic [15:0] INIT_CMD3 = 16'h1460;  // rounding on

    localparam logic [7:0] RD_BASE_ADDR = 8'hA2;

    localparam int unsigned HOLDOFF_CLKS = 4;

    // Read frame for byte idx of the burst: address in the high byte, don't-care low byte.
    function automatic logic [15:0] rd_cmd(input logic [2:0] idx);
        return {RD_BASE_ADDR + {5'd0, idx}, 8'h00};
    endfunction

    // States that own exactly one SPI frame.
    function automatic logic needs_frame(input state_t s);
        return s inside {StInit1, StInit2, StInit3, StRd0, StRd1, StRd2, StRd3, StRd4, StRd5};
    endfunction

endpackage

// File: rtl/inert_spi_reader_if.sv
// SPI pin bundle between the reader (master) and the inertial sensor (slave).
//   SS_n : select, active low
//   SCLK : serial clock, idles high (mode 3)
//   MOSI : data to sensor
//   MISO : data from sensor
interface inert_spi_reader_if;

    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);

endinterface

// File: rtl/inert_spi_xcvr.sv
// 16-bit SPI mode-3 transceiver, MSB first.
//   clk, rst_n : system clock, async active-low reset
//   wrt        : start a frame with cmd (honoured only while idle)
//   cmd        : 16-bit word shifted out on MOSI
//   done       : one-cycle pulse in the first clock after SS_n rises
//   rd_data    : the 16 bits sampled on MISO during the last frame
//   spi        : SS_n/SCLK/MOSI/MISO pins
// SCLK period is 2^SCLK_DIV_W clocks. Frame: SS_n falls, one half-period with SCLK high,
// 16 SCLK periods (fall then rise), one more half-period high, SS_n rises.
module inert_spi_xcvr
    import inert_pkg::*;
#(
    parameter int unsigned SCLK_DIV_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wrt,
    input  logic [15:0]         cmd,
    output logic                done,
    output logic [15:0]         rd_data,
    inert_spi_reader_if.master  spi
);

    localparam int unsigned HALF_W = SCLK_DIV_W - 1;

    typedef enum logic [1:0] {StIdle, StSetup, StLow, StHigh} xcvr_state_t;

    xcvr_state_t        state_q, state_d;
    logic [HALF_W-1:0]  div_q;
    logic [3:0]         bit_q;
    logic [15:0]        tx_q;
    logic [15:0]        rx_q;
    logic               done_q;
    logic               half_end;

    assign half_end = &div_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (wrt) state_d = StSetup;
            StSetup: if (half_end) state_d = StLow;
            StLow:   if (half_end) state_d = StHigh;
            StHigh:  if (half_end) state_d = (bit_q == 4'd15) ? StIdle : StLow;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            bit_q  <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == StIdle) begin
                div_q <= '0;
                if (wrt) begin
                    tx_q  <= cmd;
                    bit_q <= '0;
                end
            end else begin
                div_q <= div_q + HALF_W'(1);
            end
            // Rising SCLK edge: sample MISO.
            if (state_q == StLow && half_end) begin
                rx_q <= {rx_q[14:0], spi.MISO};
            end
            // Falling SCLK edge: advance MOSI, or close the frame after the 16th rise.
            // The first fall (out of StSetup) keeps the MSB that was loaded with SS_n.
            if (state_q == StHigh && half_end) begin
                if (bit_q == 4'd15) begin
                    done_q <= 1'b1;
                end else begin
                    tx_q  <= {tx_q[14:0], 1'b0};
                    bit_q <= bit_q + 4'd1;
                end
            end
        end
    end

    always_comb begin
        spi.SS_n = (state_q == StIdle);
        spi.SCLK = (state_q != StLow);
        spi.MOSI = tx_q[15];
    end

    assign done    = done_q;
    assign rd_data = rx_q;

endmodule

// File: rtl/inert_spi_reader.sv
// SPI sequencer for the 6-axis inertial sensor.
//   clk, rst_n : 50 MHz clock, async active-low reset
//   INT        : sensor data-ready, asynchronous level
//   spi        : SS_n/SCLK/MOSI/MISO pins
//   ptch_rt, roll_rt, yaw_rt : signed 16-bit rates, held between vld pulses
//   vld        : one-cycle strobe when all three rates update together
//   init_done  : high once the init writes finish, until reset
//   stale      : INT-timeout flag
// Waits 2^PWR_WAIT_W clocks, writes three init registers, then reads six rate bytes
// per data-ready. Optional INT timeout under `INERT_RD_TIMEOUT_EN: after 2^TO_W-1 clocks
// in WAIT_INT a burst is forced and stale is set until the next INT-driven vld.
module inert_spi_reader
    import inert_pkg::*;
#(
    parameter int unsigned PWR_WAIT_W = 16,
    parameter int unsigned SCLK_DIV_W = 5,
    parameter int unsigned TO_W       = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                INT,
    inert_spi_reader_if.master  spi,
    output logic signed [15:0]  ptch_rt,
    output logic signed [15:0]  roll_rt,
    output logic signed [15:0]  yaw_rt,
    output logic                vld,
    output logic                init_done,
    output logic                stale
);

    localparam int unsigned           HOLD_W    = $clog2(HOLDOFF_CLKS);
    localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(HOLDOFF_CLKS - 1);

    state_t                 state_q, state_d;
    logic                   int_meta_q, int_sync_q;
    logic [PWR_WAIT_W-1:0]  pwr_cnt_q;
    logic [HOLD_W-1:0]      hold_cnt_q;
    logic                   wrt_q;
    logic [15:0]            cmd;
    logic                   done;
    logic [15:0]            rd_data;
    logic [4:0][7:0]        hold_q;
    logic signed [15:0]     ptch_q, roll_q, yaw_q;
    logic                   vld_q;
    logic                   to_fire;

    inert_spi_xcvr #(
        .SCLK_DIV_W (SCLK_DIV_W)
    ) u_xcvr (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt_q),
        .cmd     (cmd),
        .done    (done),
        .rd_data (rd_data),
        .spi     (spi)
    );

    // Only the data byte of each read frame carries information.
    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data[15:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StPwrWait;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StPwrWait: if (&pwr_cnt_q) state_d = StInit1;
            StInit1:   if (done) state_d = StInit2;
            StInit2:   if (done) state_d = StInit3;
            StInit3:   if (done) state_d = StWaitInt;
            StWaitInt: if (int_sync_q || to_fire) state_d = StRd0;
            StRd0:     if (done) state_d = StRd1;
            StRd1:     if (done) state_d = StRd2;
            StRd2:     if (done) state_d = StRd3;
            StRd3:     if (done) state_d = StRd4;
            StRd4:     if (done) state_d = StRd5;
            StRd5:     if (done) state_d = StHoldoff;
            StHoldoff: if (hold_cnt_q == HOLD_LAST) state_d = StWaitInt;
            default:   state_d = StPwrWait;
        endcase
    end

    always_comb begin
        cmd       = '0;
        init_done = 1'b1;
        unique case (state_q)
            StPwrWait: init_done = 1'b0;
            StInit1:   begin cmd = INIT_CMD1; init_done = 1'b0; end
            StInit2:   begin cmd = INIT_CMD2; init_done = 1'b0; end
            StInit3:   begin cmd = INIT_CMD3; init_done = 1'b0; end
            StRd0:     cmd = rd_cmd(3'd0);
            StRd1:     cmd = rd_cmd(3'd1);
            StRd2:     cmd = rd_cmd(3'd2);
            StRd3:     cmd = rd_cmd(3'd3);
            StRd4:     cmd = rd_cmd(3'd4);
            StRd5:     cmd = rd_cmd(3'd5);
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_meta_q <= 1'b0;
            int_sync_q <= 1'b0;
            pwr_cnt_q  <= '0;
            hold_cnt_q <= '0;
            wrt_q      <= 1'b0;
            hold_q     <= '0;
            ptch_q     <= '0;
            roll_q     <= '0;
            yaw_q      <= '0;
            vld_q      <= 1'b0;
        end else begin
            int_meta_q <= INT;
            int_sync_q <= int_meta_q;
            pwr_cnt_q  <= (state_q == StPwrWait) ? pwr_cnt_q + PWR_WAIT_W'(1) : '0;
            hold_cnt_q <= (state_q == StHoldoff) ? hold_cnt_q + HOLD_W'(1) : '0;
            // One start pulse on entry to each frame state; the transceiver is idle by then,
            // and the extra cycle keeps SS_n high for two clocks between frames.
            wrt_q      <= (state_d != state_q) && needs_frame(state_d);
            vld_q      <= 1'b0;
            if (done) begin
                case (state_q)
                    StRd0: hold_q[0] <= rd_data[7:0];
                    StRd1: hold_q[1] <= rd_data[7:0];
                    StRd2: hold_q[2] <= rd_data[7:0];
                    StRd3: hold_q[3] <= rd_data[7:0];
                    StRd4: hold_q[4] <= rd_data[7:0];
                    StRd5: begin
                        ptch_q <= {hold_q[1], hold_q[0]};
                        roll_q <= {hold_q[3], hold_q[2]};
                        yaw_q  <= {rd_data[7:0], hold_q[4]};
                        vld_q  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef INERT_RD_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q;
    logic            stale_q;
    logic            forced_q;

    // A real INT wins over a coincident timeout.
    assign to_fire = (state_q == StWaitInt) && (&to_cnt_q) && !int_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            stale_q  <= 1'b0;
            forced_q <= 1'b0;
        end else begin
            // Held at zero outside WAIT_INT, so every entry starts a fresh count.
            to_cnt_q <= (state_q == StWaitInt) ? to_cnt_q + TO_W'(1) : '0;
            if (state_q == StWaitInt && state_d == StRd0) begin
                forced_q <= to_fire;
            end
            if (to_fire) begin
                stale_q <= 1'b1;
            end else if (done && state_q == StRd5 && !forced_q) begin
                stale_q <= 1'b0;
            end
        end
    end

    assign stale = stale_q;
`else
    assign to_fire = 1'b0;
    assign stale   = 1'b0;

    // TO_W only sizes the timeout counter, which this build does not have.
    logic unused_to_w;
    assign unused_to_w = ^TO_W;
`endif

    assign ptch_rt = ptch_q;
    assign roll_rt = roll_q;
    assign yaw_rt  = yaw_q;
    assign vld     = vld_q;

endmodule
